// File: rtl/anton_neopixel_sequencer.sv
// rtl/anton_neopixel_sequencer.sv - NeoPixel frame timing sequencer (slot/bit/pixel walk plus inter-frame reset gap)
module anton_neopixel_sequencer #(
    parameter int  BUFFER_END  = 255,
    parameter int  RESET_DELAY = 600,
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1),
    localparam int DELAY_BITS  = $clog2(RESET_DELAY + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   syncRst,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic                   regCtrlInit,
    input  logic [BUFFER_BITS-1:0] regPixelMax,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   streamSyncOf
);

    typedef enum logic {
        ST_RESET    = 1'b0,
        ST_TRANSMIT = 1'b1
    } seq_state_t;

    localparam logic [BUFFER_BITS-1:0] BUF_END_V = BUFFER_BITS'(BUFFER_END);
    localparam logic [DELAY_BITS-1:0]  GAP_LAST  = DELAY_BITS'(RESET_DELAY - 1);

    seq_state_t             state_q, state_d;
    logic [BUFFER_BITS-1:0] pix_q, pix_d;
    logic [4:0]             bit_q, bit_d;
    logic [2:0]             slot_q, slot_d;
    logic                   sync_q, sync_d;
    logic [DELAY_BITS-1:0]  gap_q, gap_d;
    logic                   done_q, done_d;

    logic [BUFFER_BITS-1:0] pix_max;
    logic                   is_last;
    logic [BUFFER_BITS-1:0] pix_adv;

    assign pix_max = (regPixelMax > BUF_END_V) ? BUF_END_V : regPixelMax;

    // In 32-bit mode only whole 4-byte words are compared and stepped.
    assign is_last = regCtrl32bit ? (pix_q[BUFFER_BITS-1:2] >= pix_max[BUFFER_BITS-1:2])
                                  : (pix_q >= pix_max);
    assign pix_adv = regCtrl32bit ? {pix_q[BUFFER_BITS-1:2] + (BUFFER_BITS-2)'(1), 2'b00}
                                  : pix_q + BUFFER_BITS'(1);

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        bit_d   = bit_q;
        slot_d  = slot_q;
        gap_d   = gap_q;
        done_d  = done_q;
        sync_d  = 1'b0;
        if (regCtrlInit) begin
            state_d = ST_RESET;
            pix_d   = '0;
            bit_d   = '0;
            slot_d  = '0;
            gap_d   = '0;
            done_d  = 1'b0;
        end else if (regCtrlRun) begin
            case (state_q)
                ST_RESET: begin
                    pix_d  = '0;
                    bit_d  = '0;
                    slot_d = '0;
                    if (!done_q) begin
                        if (gap_q == GAP_LAST) begin
                            gap_d   = '0;
                            state_d = ST_TRANSMIT;
                        end else begin
                            gap_d = gap_q + DELAY_BITS'(1);
                        end
                    end
                end
                ST_TRANSMIT: begin
                    slot_d = slot_q + 3'd1;
                    if (slot_q == 3'd7) begin
                        if (bit_q == 5'd23) begin
                            bit_d = '0;
                            if (is_last) begin
                                state_d = ST_RESET;
                                pix_d   = '0;
                                gap_d   = '0;
                                sync_d  = 1'b1;
                                done_d  = !regCtrlLoop;
                            end else begin
                                pix_d = pix_adv;
                            end
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (!syncRst) begin
            state_q <= ST_RESET;
            pix_q   <= '0;
            bit_q   <= '0;
            slot_q  <= '0;
            sync_q  <= 1'b0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            sync_q  <= sync_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    assign state           = state_q;
    assign pixelIndex      = pix_q;
    assign pixelBitIndex   = bit_q;
    assign bitPatternIndex = slot_q;
    assign streamSyncOf    = sync_q;

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// tb/tb_anton_neopixel_sequencer.sv - self-checking bench for anton_neopixel_sequencer
module tb_anton_neopixel_sequencer;

    localparam int BE = 7;
    localparam int RD = 16;
    localparam int BB = 3;

    logic          clk = 1'b0;
    logic          rstn, run, loop_en, b32, init;
    logic [BB-1:0] pmax;
    logic          state;
    logic [BB-1:0] pix;
    logic [4:0]    bit_idx;
    logic [2:0]    slot;
    logic          sync;

    always #5 clk = ~clk;

    anton_neopixel_sequencer #(.BUFFER_END(BE), .RESET_DELAY(RD)) dut (
        .clk6_4mhz      (clk),
        .syncRst        (rstn),
        .regCtrlRun     (run),
        .regCtrlLoop    (loop_en),
        .regCtrl32bit   (b32),
        .regCtrlInit    (init),
        .regPixelMax    (pmax),
        .state          (state),
        .pixelIndex     (pix),
        .pixelBitIndex  (bit_idx),
        .bitPatternIndex(slot),
        .streamSyncOf   (sync)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference: position within a pixel as a single 0..191 cycle count.
    int m_tx, m_gap, m_p, m_pix, m_done, m_sync;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    task automatic model_step();
        int cm;
        bit last;
        if (!rstn || init) begin
            m_tx = 0; m_gap = 0; m_p = 0; m_pix = 0; m_done = 0; m_sync = 0;
        end else if (run) begin
            m_sync = 0;
            if (m_tx == 0) begin
                if (m_done == 0) begin
                    if (m_gap == RD - 1) begin
                        m_gap = 0;
                        m_tx  = 1;
                        m_p   = 0;
                    end else begin
                        m_gap++;
                    end
                end
            end else if (m_p == 191) begin
                cm   = (int'(pmax) > BE) ? BE : int'(pmax);
                last = b32 ? (m_pix / 4 >= cm / 4) : (m_pix >= cm);
                m_p  = 0;
                if (last) begin
                    m_tx = 0; m_pix = 0; m_gap = 0; m_sync = 1;
                    m_done = loop_en ? 0 : 1;
                end else begin
                    m_pix = b32 ? (m_pix / 4 + 1) * 4 : m_pix + 1;
                end
            end else begin
                m_p++;
            end
        end else begin
            m_sync = 0;
        end
    endtask

    task automatic step();
        int act, exp;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        act = int'({state, pix, bit_idx, slot, sync});
        exp = (m_tx << 12) | (m_pix << 9) | ((m_p / 8) << 4) | ((m_p % 8) << 1) | m_sync;
        check("model", act, exp);
    endtask

    task automatic do_reset(input bit lp, input bit w32, input int pm);
        rstn = 1'b0; init = 1'b0; run = 1'b1;
        loop_en = lp; b32 = w32; pmax = BB'(pm);
        repeat (3) step();
        rstn = 1'b1;
        cyc  = 0;
    endtask

    typedef struct {
        bit lp; bit w32; int pm; int cyc;
        int st; int px; int bi; int sl; int sy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit lp, input bit w32, input int pm, input int c,
                                input int st, input int px, input int bi, input int sl, input int sy);
        vec_t v;
        v.lp = lp; v.w32 = w32; v.pm = pm; v.cyc = c;
        v.st = st; v.px = px; v.bi = bi; v.sl = sl; v.sy = sy;
        vecs.push_back(v);
    endfunction

    initial begin
        rstn = 1'b0; run = 1'b0; loop_en = 1'b0; b32 = 1'b0; init = 1'b0; pmax = '0;
        m_tx = 0; m_gap = 0; m_p = 0; m_pix = 0; m_done = 0; m_sync = 0;
        @(negedge clk);

        // Reset state
        do_reset(0, 0, 2);
        check("rst_state", int'(state), 0);
        check("rst_pix", int'(pix), 0);
        check("rst_bit", int'(bit_idx), 0);
        check("rst_slot", int'(slot), 0);
        check("rst_sync", int'(sync), 0);

        // Single frame 8-bit, pixelMax=2
        add(0,0,2,   0, 0,0,0,0,0);  add(0,0,2,  15, 0,0,0,0,0);
        add(0,0,2,  16, 1,0,0,0,0);  add(0,0,2,  20, 1,0,0,4,0);
        add(0,0,2, 207, 1,0,23,7,0); add(0,0,2, 208, 1,1,0,0,0);
        add(0,0,2, 400, 1,2,0,0,0);  add(0,0,2, 591, 1,2,23,7,0);
        add(0,0,2, 592, 0,0,0,0,1);  add(0,0,2, 593, 0,0,0,0,0);
        add(0,0,2,1500, 0,0,0,0,0);
        // Loop mode
        add(1,0,2, 592, 0,0,0,0,1);  add(1,0,2, 607, 0,0,0,0,0);
        add(1,0,2, 608, 1,0,0,0,0);  add(1,0,2,1183, 1,2,23,7,0);
        add(1,0,2,1184, 0,0,0,0,1);  add(1,0,2,1200, 1,0,0,0,0);
        // 32-bit mode
        add(0,1,7,  16, 1,0,0,0,0);  add(0,1,7, 207, 1,0,23,7,0);
        add(0,1,7, 208, 1,4,0,0,0);  add(0,1,7, 399, 1,4,23,7,0);
        add(0,1,7, 400, 0,0,0,0,1);  add(0,1,7, 800, 0,0,0,0,0);
        add(0,1,6, 208, 1,4,0,0,0);  add(0,1,6, 400, 0,0,0,0,1);
        add(0,1,3, 208, 0,0,0,0,1);
        // Boundary pixel counts in 8-bit mode
        add(0,0,0, 208, 0,0,0,0,1);
        add(0,0,7,1551, 1,7,23,7,0); add(0,0,7,1552, 0,0,0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].lp != loop_en || vecs[i].w32 != b32 ||
                BB'(vecs[i].pm) != pmax || vecs[i].cyc < cyc)
                do_reset(vecs[i].lp, vecs[i].w32, vecs[i].pm);
            while (cyc < vecs[i].cyc) step();
            check("vec_state", int'(state),   vecs[i].st);
            check("vec_pix",   int'(pix),     vecs[i].px);
            check("vec_bit",   int'(bit_idx), vecs[i].bi);
            check("vec_slot",  int'(slot),    vecs[i].sl);
            check("vec_sync",  int'(sync),    vecs[i].sy);
        end

        // Freeze for 10 cycles at slot 5
        do_reset(0, 0, 2);
        while (cyc < 21) step();
        check("frz_pre_slot", int'(slot), 5);
        run = 1'b0;
        repeat (10) begin
            step();
            check("frz_hold_slot", int'(slot), 5);
            check("frz_hold_state", int'(state), 1);
            check("frz_hold_sync", int'(sync), 0);
        end
        run = 1'b1;
        step();
        check("frz_resume_slot", int'(slot), 6);
        while (cyc < 601) step();
        check("frz_sync_early", int'(sync), 0);
        step();
        check("frz_sync_late", int'(sync), 1);

        // Mid-frame restart at pixel 1, bit 9
        do_reset(0, 0, 2);
        while (cyc < 280) step();
        check("ini_pre_pix", int'(pix), 1);
        check("ini_pre_bit", int'(bit_idx), 9);
        init = 1'b1;
        step();
        init = 1'b0;
        check("ini_state", int'(state), 0);
        check("ini_pix", int'(pix), 0);
        check("ini_bit", int'(bit_idx), 0);
        check("ini_slot", int'(slot), 0);
        check("ini_sync", int'(sync), 0);
        repeat (15) begin
            step();
            check("ini_gap_state", int'(state), 0);
            check("ini_gap_sync", int'(sync), 0);
        end
        step();
        check("ini_restart", int'(state), 1);

        // Randomized run against the reference model
        do_reset(1, 0, 3);
        for (int n = 0; n < 6000; n++) begin
            if (n % 300 == 0) begin
                loop_en = ($urandom % 4) != 0;
                b32     = $urandom % 2;
                pmax    = BB'($urandom);
            end
            run  = ($urandom % 10) != 0;
            init = ($urandom % 400) == 0;
            rstn = ($urandom % 1000) != 0;
            step();
        end
        rstn = 1'b1; init = 1'b0; run = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_sequencer.md
# anton_neopixel_sequencer

Timing sequencer that sits directly upstream of the NeoPixel stream encoder. It runs in the 6.4 MHz pixel clock domain, where one clock is one of 8 pattern slots of a 1.25 µs NeoPixel bit. It generates the `state`, `pixelIndex`, `pixelBitIndex` and `bitPatternIndex` sequence that walks the pixel buffer, inserts the mandatory low reset gap between frames, and pulses a frame-end marker for the register/interrupt logic.

## Interface

**Parameters**
- `BUFFER_END`, default `` `BUFFER_END_DEFAULT ``: last valid byte index of the pixel buffer.
- `BUFFER_BITS`, localparam `` `CLOG2(BUFFER_END+1) ``: width of the pixel index.
- `RESET_DELAY`, default 600: cycles spent in the reset state between frames (93.75 µs at 6.4 MHz; must be ≥320).
- `DELAY_BITS`, localparam `` `CLOG2(RESET_DELAY+1) ``: width of the reset-gap counter.

**Ports**
- `clk6_4mhz` in 1: the only clock. Reset is synchronous and active-low.
- `syncRst` in 1: synchronous, active-low reset.
- `regCtrlRun` in 1: 1 = sequencer advances; 0 = every counter and the state hold.
- `regCtrlLoop` in 1: 1 = frames repeat; 0 = one frame, then idle.
- `regCtrl32bit` in 1: 1 = 4 bytes per pixel; 0 = 1 byte per pixel.
- `regCtrlInit` in 1: one-cycle pulse that restarts the sequence from scratch.
- `regPixelMax` in `BUFFER_BITS`: last byte index to transmit. Values above `BUFFER_END` are clamped to `BUFFER_END`.
- `state` out 1: `` `ENUM_STATE_RESET `` or `` `ENUM_STATE_TRANSMIT ``.
- `pixelIndex` out `BUFFER_BITS`: current byte index. In 32-bit mode bits [1:0] are always 0.
- `pixelBitIndex` out 5: 0–23, the bit of the 24-bit colour word. Bit 0 is sent first.
- `bitPatternIndex` out 3: 0–7, the slot within the current bit pattern.
- `streamSyncOf` out 1: one-cycle pulse at the end of every frame.

## Operation

All outputs are registered.

**Reset and restart**
- `syncRst`=0 at an edge sets `state`=RESET and clears `pixelIndex`, `pixelBitIndex`, `bitPatternIndex`, `streamSyncOf`, the gap counter and the internal `frameDone` flag.
- `regCtrlInit`=1 has the same effect.
- Priority: `syncRst` > `regCtrlInit` > `regCtrlRun` gating.
- `regCtrlRun`=0 freezes everything, including the gap counter. `streamSyncOf` is forced to 0 while frozen.

**RESET state**
- `pixelIndex`, `pixelBitIndex` and `bitPatternIndex` are held at 0.
- If `frameDone`=0, the gap counter counts 0 → `RESET_DELAY`-1. On terminal count the counter clears and the block enters TRANSMIT.
- If `frameDone`=1, the block idles in RESET until `regCtrlInit`.

**TRANSMIT state**
- `bitPatternIndex` increments every cycle and wraps 7→0.
- On each 7→0 wrap, `pixelBitIndex` increments and wraps 23→0.
- On each 23→0 wrap, the pixel advances:
  - Last-pixel test: 8-bit mode uses `pixelIndex` ≥ clamped `regPixelMax`; 32-bit mode uses `pixelIndex[BUFFER_BITS-1:2]` ≥ `regPixelMax[BUFFER_BITS-1:2]`.
  - Not last: `pixelIndex` advances by 1 (8-bit) or by 4 with bits [1:0] forced to 0 (32-bit). The comparison is made before the add, so the index never wraps or overflows.
  - Last: `state` goes to RESET, `pixelIndex` goes to 0, the gap counter clears, `streamSyncOf` is 1 for exactly that next cycle, and `frameDone` takes the value !`regCtrlLoop`.

**Other rules**
- A change of `regCtrl32bit` or `regPixelMax` mid-frame takes effect at the next pixel advance.
- If `regCtrl32bit` switches to 1 mid-frame, bits [1:0] are masked on the next advance.

## Timing

- One bit = 8 cycles. One pixel = 192 cycles.
- Frame transmit length = number of pixels × 192. Pixel count is `regPixelMax`+1 in 8-bit mode and `regPixelMax[..:2]`+1 in 32-bit mode.
- After `syncRst` is released with `regCtrlRun`=1: `state`=TRANSMIT is first visible on cycle `RESET_DELAY`, counting from 0 at the first non-reset edge.
- `streamSyncOf` coincides with the first RESET cycle after a frame.
- In loop mode the next TRANSMIT begins exactly `RESET_DELAY` cycles after `streamSyncOf`.
- Frame period = transmit length + `RESET_DELAY`.
- A freeze (`regCtrlRun`=0) of N cycles stretches the timeline by exactly N cycles.

## Test plan

Bench configuration: `BUFFER_END`=7, `RESET_DELAY`=16.

1. **Reset:** hold `syncRst`=0 for 3 cycles → `state`=RESET; `pixelIndex`, `pixelBitIndex`, `bitPatternIndex` and `streamSyncOf` all 0.
2. **Single frame, 8-bit:** run=1, loop=0, 8-bit, `regPixelMax`=2 → TRANSMIT starts at cycle 16. `pixelIndex` is 0/1/2 for 192 cycles each. `streamSyncOf` pulses at cycle 592. The block then stays in RESET indefinitely.
3. **Loop mode:** same as scenario 2 with loop=1 → the second TRANSMIT starts at cycle 608 and the second `streamSyncOf` pulses at cycle 1184.
4. **32-bit mode:** 32-bit, `regPixelMax`=7 → `pixelIndex` is 0 then 4, 384 transmit cycles in total. `regPixelMax`=15 is clamped and gives the same result.
5. **Freeze:** drop run at `bitPatternIndex`=5 for 10 cycles → all outputs hold. The block resumes at slot 6, and `streamSyncOf` is delayed by 10 cycles.
6. **Mid-frame restart:** pulse `regCtrlInit` at `pixelIndex`=1, `pixelBitIndex`=9 → next cycle `state`=RESET with all counters 0. TRANSMIT restarts 16 cycles later with no `streamSyncOf` pulse.
